sc_speedtick_generator: RTL and testbench

Consumer and controller for the upSPEEDCOUNTER stage in the game-speed path. It compares the counter's value bus against a per-level threshold and emits a one-cycle speed tick, which downstream sprite/lane movement logic uses. It also drives the counter's active-low count enable and its active-high clear, closing the loop. A small FSM provides start, pause and stop control.

---
 rtl/sc_speedtick_generator.sv | 122 ++++++++++++
 tb/tb_sc_speedtick_generator.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sc_speedtick_generator.sv
`default_nettype none
// ---- sc_speedtick_generator : per-level threshold compare on the speed counter, emitting a one-cycle tick
// ---- and closing the count-enable/clear loop under a start/pause/stop FSM.            Rev 1.0
module sc_speedtick_generator #(
  parameter int DATAWIDTH = 25,
  parameter int LVL1_W    = 25,
  parameter int LVL2_W    = 24,
  parameter int LVL3_W    = 23,
  parameter int LVL4_W    = 22,
  parameter int TICKCNT_W = 8
) (
  input  logic                 SC_SPEEDTICK_CLOCK_50,
  input  logic                 SC_SPEEDTICK_RESET_InLow,
  input  logic [DATAWIDTH-1:0] SC_SPEEDTICK_count_InBUS,
  input  logic [1:0]           SC_SPEEDTICK_level_InBUS,
  input  logic                 SC_SPEEDTICK_start_InHigh,
  input  logic                 SC_SPEEDTICK_pause_InHigh,
  input  logic                 SC_SPEEDTICK_stop_InHigh,
  output logic                 SC_SPEEDTICK_tick_Out,
  output logic                 SC_SPEEDTICK_upcount_OutLow,
  output logic                 SC_SPEEDTICK_clear_OutHigh,
  output logic [1:0]           SC_SPEEDTICK_level_OutBUS,
  output logic [TICKCNT_W-1:0] SC_SPEEDTICK_tickcnt_OutBUS
);

  // State encoding is {tick, clear, upcount}: every output is a flop bit, so clear never glitches.
  localparam logic [2:0] IDLE  = 3'b011;
  localparam logic [2:0] RUN   = 3'b000;
  localparam logic [2:0] TICK  = 3'b111;
  localparam logic [2:0] PAUSE = 3'b001;

  // Thresholds carry one extra bit so an exponent equal to DATAWIDTH still fits.
  localparam logic [DATAWIDTH:0] ONE_EXT = {{DATAWIDTH{1'b0}}, 1'b1};
  localparam logic [DATAWIDTH:0] THR0    = (ONE_EXT << LVL1_W) - ONE_EXT;
  localparam logic [DATAWIDTH:0] THR1    = (ONE_EXT << LVL2_W) - ONE_EXT;
  localparam logic [DATAWIDTH:0] THR2    = (ONE_EXT << LVL3_W) - ONE_EXT;
  localparam logic [DATAWIDTH:0] THR3    = (ONE_EXT << LVL4_W) - ONE_EXT;

  logic [2:0]           state_q, state_d;
  logic [1:0]           level_q, level_d;
  logic [TICKCNT_W-1:0] tickcnt_q, tickcnt_d;
  logic [DATAWIDTH:0]   thr;
  logic                 match;

  always_comb begin
    thr = THR0;
    case (level_q)
      2'd0:    thr = THR0;
      2'd1:    thr = THR1;
      2'd2:    thr = THR2;
      default: thr = THR3;
    endcase
  end

  // >= rather than == so a switch to a faster level above the new threshold still fires.
  assign match = ({1'b0, SC_SPEEDTICK_count_InBUS} >= thr);

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    tickcnt_d = tickcnt_q;
    case (state_q)
      IDLE: begin
        if (!SC_SPEEDTICK_stop_InHigh && SC_SPEEDTICK_start_InHigh) begin
          state_d = RUN;
          level_d = SC_SPEEDTICK_level_InBUS;
        end
      end
      RUN: begin
        if (SC_SPEEDTICK_stop_InHigh) begin
          state_d = IDLE;
        end else if (SC_SPEEDTICK_pause_InHigh) begin
          state_d = PAUSE;
        end else if (match) begin
          state_d   = TICK;
          level_d   = SC_SPEEDTICK_level_InBUS;
          tickcnt_d = tickcnt_q + TICKCNT_W'(1);
        end
      end
      TICK: begin
        if (SC_SPEEDTICK_stop_InHigh) begin
          state_d = IDLE;
        end else if (SC_SPEEDTICK_pause_InHigh) begin
          state_d = PAUSE;
        end else begin
          state_d = RUN;
        end
      end
      PAUSE: begin
        if (SC_SPEEDTICK_stop_InHigh) begin
          state_d = IDLE;
        end else if (!SC_SPEEDTICK_pause_InHigh) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    if (SC_SPEEDTICK_stop_InHigh) begin
      tickcnt_d = '0;
    end
  end

  always_ff @(posedge SC_SPEEDTICK_CLOCK_50 or negedge SC_SPEEDTICK_RESET_InLow) begin
    if (!SC_SPEEDTICK_RESET_InLow) begin
      state_q   <= IDLE;
      level_q   <= 2'd0;
      tickcnt_q <= '0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      tickcnt_q <= tickcnt_d;
    end
  end

  assign SC_SPEEDTICK_tick_Out       = state_q[2];
  assign SC_SPEEDTICK_clear_OutHigh  = state_q[1];
  assign SC_SPEEDTICK_upcount_OutLow = state_q[0];
  assign SC_SPEEDTICK_level_OutBUS   = level_q;
  assign SC_SPEEDTICK_tickcnt_OutBUS = tickcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sc_speedtick_generator.sv
`default_nettype none
// ---- tb_sc_speedtick_generator : directed bench with a behavioural speed counter in the loop.
// ---- Rev 1.0
module tb_sc_speedtick_generator;

  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] cnt;
  logic [1:0]    level_in;
  logic          start, pause, stop;
  logic          tick, upcount, clear;
  logic [1:0]    level_out;
  logic [7:0]    tickcnt;

  int n_checks = 0;
  int n_fail   = 0;

  sc_speedtick_generator #(
    .DATAWIDTH(DW), .LVL1_W(4), .LVL2_W(3), .LVL3_W(2), .LVL4_W(1), .TICKCNT_W(8)
  ) dut (
    .SC_SPEEDTICK_CLOCK_50      (clk),
    .SC_SPEEDTICK_RESET_InLow   (rst_n),
    .SC_SPEEDTICK_count_InBUS   (cnt),
    .SC_SPEEDTICK_level_InBUS   (level_in),
    .SC_SPEEDTICK_start_InHigh  (start),
    .SC_SPEEDTICK_pause_InHigh  (pause),
    .SC_SPEEDTICK_stop_InHigh   (stop),
    .SC_SPEEDTICK_tick_Out      (tick),
    .SC_SPEEDTICK_upcount_OutLow(upcount),
    .SC_SPEEDTICK_clear_OutHigh (clear),
    .SC_SPEEDTICK_level_OutBUS  (level_out),
    .SC_SPEEDTICK_tickcnt_OutBUS(tickcnt)
  );

  // Stand-in for the upSPEEDCOUNTER: async active-high clear, counts while enable is low.
  always_ff @(posedge clk or posedge clear) begin
    if (clear)         cnt <= '0;
    else if (!upcount) cnt <= cnt + 8'd1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until tick is seen; n is the number of clock edges taken.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < 2000);
    if (!tick) check_eq("tick_timeout", tick, 1);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] lvl);
    level_in = lvl;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  initial begin
    int n;
    int m;
    rst_n = 1'b0; level_in = 2'd0; start = 1'b0; pause = 1'b0; stop = 1'b0;
    step(); step();
    check_eq("rst_tick",    tick,      0);
    check_eq("rst_upcount", upcount,   1);
    check_eq("rst_clear",   clear,     1);
    check_eq("rst_level",   level_out, 0);
    check_eq("rst_tickcnt", tickcnt,   0);
    rst_n = 1'b1;
    step();
    check_eq("idle_hold", upcount, 1);

    // Level 0: thr = 15, period 17.
    do_start(2'd0);
    check_eq("run_upcount", upcount, 0);
    check_eq("run_clear",   clear,   0);
    wait_tick(n);
    check_eq("t1_first", n + 1, 17);
    check_eq("t1_clear_in_tick",   clear,   1);
    check_eq("t1_upcount_in_tick", upcount, 1);
    for (int k = 1; k <= 3; k++) begin
      step();
      check_eq("t1_tickcnt", tickcnt, k);
      check_eq("t1_tick_width", tick, 0);
      if (k < 3) begin
        wait_tick(n);
        check_eq("t1_period", n + 1, 17);
      end
    end

    // Level 3: thr = 1, period 3.
    do_stop();
    check_eq("t2_stop_tickcnt", tickcnt, 0);
    do_start(2'd3);
    wait_tick(n);
    check_eq("t2_first", n + 1, 3);
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("t2_tick_width", tick, 0);
      wait_tick(n);
      check_eq("t2_period", n + 1, 3);
      check_eq("t2_clear_in_tick", clear, 1);
    end

    // Pause 5 cycles at count 7 on level 0.
    do_stop();
    do_start(2'd0);
    wait_tick(n);
    m = 0;
    do begin step(); m++; end while (cnt != 8'd6 && m < 100);
    pause = 1'b1;
    step(); m++;
    check_eq("t3_pause_cnt",     cnt,     7);
    check_eq("t3_pause_upcount", upcount, 1);
    check_eq("t3_pause_clear",   clear,   0);
    for (int k = 0; k < 4; k++) begin step(); m++; end
    check_eq("t3_pause_hold", cnt, 7);
    pause = 1'b0;
    wait_tick(n);
    check_eq("t3_period", m + n, 22);

    // Level change mid-period is deferred to the next tick.
    m = 0;
    do begin step(); m++; end while (cnt != 8'd10 && m < 100);
    level_in = 2'd3;
    step(); m++;
    check_eq("t4_level_deferred", level_out, 0);
    wait_tick(n);
    check_eq("t4_period_old", m + n, 17);
    check_eq("t4_level_in_tick", level_out, 3);
    wait_tick(n);
    check_eq("t4_period_new", n, 3);

    // Stop from RUN and from PAUSE.
    step();
    do_stop();
    check_eq("t5_run_stop_clear",   clear,   1);
    check_eq("t5_run_stop_upcount", upcount, 1);
    check_eq("t5_run_stop_tickcnt", tickcnt, 0);
    check_eq("t5_run_stop_cnt",     cnt,     0);
    do_start(2'd3);
    check_eq("t5_restart_level", level_out, 3);
    wait_tick(n);
    check_eq("t5_restart_first", n + 1, 3);
    step();
    pause = 1'b1;
    step();
    check_eq("t5_in_pause_clear", clear, 0);
    stop = 1'b1;
    step();
    stop = 1'b0; pause = 1'b0;
    check_eq("t5_pause_stop_clear",   clear,   1);
    check_eq("t5_pause_stop_tickcnt", tickcnt, 0);
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check_eq("t5_start_stop_idle", upcount, 1);
    step();
    check_eq("t5_still_idle", clear, 1);

    // Tick counter wrap.
    do_start(2'd3);
    for (int k = 0; k < 255; k++) wait_tick(n);
    step();
    check_eq("t6_tickcnt_255", tickcnt, 255);
    wait_tick(n);
    step();
    check_eq("t6_tickcnt_wrap", tickcnt, 0);

    // Asynchronous reset mid-period.
    do_stop();
    do_start(2'd0);
    for (int k = 0; k < 5; k++) step();
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_areset_tick",    tick,      0);
    check_eq("t6_areset_upcount", upcount,   1);
    check_eq("t6_areset_clear",   clear,     1);
    check_eq("t6_areset_level",   level_out, 0);
    check_eq("t6_areset_cnt",     cnt,       0);
    for (int k = 0; k < 20; k++) begin
      step();
      if (tick) check_eq("t6_no_tick_in_reset", tick, 0);
    end
    rst_n = 1'b1;
    step();
    check_eq("t6_post_reset_tickcnt", tickcnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
